// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
// Byte-request and transmitter handshake bundle for uart_tx_arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2
);
  logic [N_REQ-1:0]                 req;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]                 ack;
  logic [DATA_WIDTH-1:0]            tx_data;
  logic                             tx_start;
  logic                             tx_end;
  logic                             busy;
  logic [ID_WIDTH-1:0]              cur_id;
  logic                             timeout_err;

  modport master (
    input  req, req_data, tx_end,
    output ack, tx_data, tx_start, busy, cur_id, timeout_err
  );

  modport slave (
    output req, req_data, tx_end,
    input  ack, tx_data, tx_start, busy, cur_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers,
// with a watchdog that aborts any frame whose tx_end never arrives.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 64,
  parameter int CNT_WIDTH  = 7
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERR} state_t;

  state_t                state, state_d;
  logic [CNT_WIDTH-1:0]  cnt, cnt_d;
  logic [ID_WIDTH-1:0]   cur_id, cur_id_d;
  logic [ID_WIDTH-1:0]   rr_ptr, rr_ptr_d;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [DATA_WIDTH-1:0] tx_data, tx_data_d;
  logic [N_REQ-1:0]      ahead;
  logic [N_REQ-1:0]      req_ahead;

  function automatic logic [ID_WIDTH-1:0] lowest_set(input logic [N_REQ-1:0] v);
    lowest_set = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (v[i]) lowest_set = ID_WIDTH'(i);
  endfunction

  // Requesters above the last winner get first pick; otherwise wrap to the lowest.
  generate
    for (genvar g = 0; g < N_REQ; g++) begin : g_ahead
      assign ahead[g] = (ID_WIDTH'(g) > rr_ptr);
    end
  endgenerate

  assign req_ahead = bus.req & ahead;
  assign grant_id  = (|req_ahead) ? lowest_set(req_ahead) : lowest_set(bus.req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_id  <= '0;
      rr_ptr  <= ID_WIDTH'(N_REQ-1);
      tx_data <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cur_id  <= cur_id_d;
      rr_ptr  <= rr_ptr_d;
      tx_data <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cur_id_d  = cur_id;
    rr_ptr_d  = rr_ptr;
    tx_data_d = tx_data;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          cur_id_d  = grant_id;
          tx_data_d = bus.req_data[grant_id];
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        // Completion beats the watchdog when both land on the same cycle.
        if (bus.tx_end)                              state_d = DONE;
        else if (cnt == CNT_WIDTH'(TIMEOUT-1))       state_d = ERR;
      end
      DONE, ERR: begin
        rr_ptr_d = cur_id;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only.
  assign bus.tx_start    = (state == START);
  assign bus.busy        = (state != IDLE);
  assign bus.timeout_err = (state == ERR);
  assign bus.ack         = (state == DONE) ? (N_REQ'(1) << cur_id) : '0;
  assign bus.tx_data     = tx_data;
  assign bus.cur_id      = cur_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_arbiter: a frame-level reference model is checked
// against the DUT every cycle, plus literal checks on grants, bytes and latencies.
module tb_uart_tx_arbiter;
  localparam int DW = 8, NR = 4, IDW = 2, TO = 64, CW = 7;

  bit clk = 0;
  bit reset = 0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IDW)) bus ();

  uart_tx_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR), .ID_WIDTH(IDW), .TIMEOUT(TO), .CNT_WIDTH(CW))
    dut (.clk(clk), .reset(reset), .bus(bus.master));

  int tests = 0;
  int fails = 0;
  bit drop_on_ack = 1;

  // Transmitter stand-in: tx_end pulses te_a / te_b cycles after the tx_start cycle.
  int te_a = -1, te_b = -1, since = 100000;
  bit te_pulse = 0;
  assign bus.tx_end = te_pulse;
  always @(negedge clk) begin
    if (bus.tx_start) since = 0;
    else if (since < 100000) since++;
    te_pulse = (since == te_a) || (since == te_b);
  end

  // Frame-level model: age counts cycles since the grant edge (0 = tx_start cycle).
  bit        m_act = 0, m_gap = 0, m_err = 0;
  int        m_age = 0, m_rr = NR-1, m_id = 0, hit;
  logic [7:0] m_data = '0;
  logic [3:0] m_ack = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_gap = 0; m_err = 0; m_age = 0;
      m_rr = NR-1; m_id = 0; m_data = '0; m_ack = '0;
    end else begin
      m_ack = '0; m_err = 0;
      if (m_gap) m_gap = 0;
      else if (!m_act) begin
        hit = -1;
        for (int k = 1; k <= NR; k++)
          if (hit < 0 && bus.req[(m_rr+k)%NR]) hit = (m_rr+k)%NR;
        if (hit >= 0) begin
          m_act = 1; m_id = hit; m_data = bus.req_data[hit]; m_age = 0;
        end
      end else if (m_age == 0) m_age = 1;
      else if (bus.tx_end) begin
        m_ack = 4'(1 << m_id); m_rr = m_id; m_act = 0; m_gap = 1;
      end else if (m_age == TO) begin
        m_err = 1; m_rr = m_id; m_act = 0; m_gap = 1;
      end else m_age++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: model-vs-DUT compare, then requester drops any acked request.
  task automatic tick();
    logic [16:0] e, a;
    @(negedge clk);
    if (!reset) begin
      e = {m_act | m_gap, m_act && (m_age == 0), m_err, m_ack, 2'(m_id), m_data};
      a = {bus.busy, bus.tx_start, bus.timeout_err, bus.ack, bus.cur_id, bus.tx_data};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t: got busy/start/err/ack/id/data=%h, expected %h", $time, a, e);
      end
    end
    if (drop_on_ack) bus.req = bus.req & ~bus.ack;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return bus.tx_start;
      1:       return |bus.ack;
      default: return bus.timeout_err;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string name, output time t);
    int n;
    n = 0;
    while (!sig(which) && n < 300) begin tick(); n++; end
    if (!sig(which)) begin
      tests++; fails++;
      $display("FAIL %s: no event after %0d cycles, event required", name, n);
    end
    t = $time;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    bus.req = '0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    time ts, ta, tt;
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    bus.req = '0;
    bus.req_data = '0;

    // Reset state
    #1 reset = 1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_start", bus.tx_start, 0);
    check("rst_err", bus.timeout_err, 0);
    check("rst_id", bus.cur_id, 0);
    check("rst_data", bus.tx_data, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    tick();

    // Single request
    te_a = 10; te_b = -1; drop_on_ack = 1;
    bus.req_data[2] = 8'hDB;
    bus.req = 4'b0100;
    wait_sig(0, "single_start", ts);
    check("single_data", bus.tx_data, 8'hDB);
    check("single_id", bus.cur_id, 2);
    wait_sig(1, "single_ack", ta);
    check("single_ack_val", bus.ack, 4'b0100);
    check("single_latency", (ta - ts) / 10, 11);
    tick();
    check("single_busy_low", bus.busy, 0);

    // Simultaneous requests from reset
    do_reset();
    te_a = 4;
    bus.req_data[1] = 8'h11;
    bus.req_data[3] = 8'h33;
    bus.req = 4'b1010;
    wait_sig(0, "sim_start0", ts);
    check("sim_id0", bus.cur_id, 1);
    check("sim_data0", bus.tx_data, 8'h11);
    wait_sig(1, "sim_ack0", ta);
    check("sim_ack0_val", bus.ack, 4'b0010);
    wait_sig(0, "sim_start1", ts);
    check("sim_id1", bus.cur_id, 3);
    check("sim_data1", bus.tx_data, 8'h33);
    wait_sig(1, "sim_ack1", ta);
    check("sim_ack1_val", bus.ack, 4'b1000);
    bus.req_data[1] = 8'h5A;
    bus.req = 4'b0010;
    wait_sig(0, "sim_start2", ts);
    check("sim_id2", bus.cur_id, 1);
    check("sim_data2", bus.tx_data, 8'h5A);
    wait_sig(1, "sim_ack2", ta);

    // Continuous requests: strict rotation
    do_reset();
    te_a = 12; drop_on_ack = 0;
    for (int i = 0; i < NR; i++) bus.req_data[i] = 8'hA0 + 8'(i);
    bus.req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_sig(0, "cont_start", ts);
      check("cont_id", bus.cur_id, exp_seq[n]);
      check("cont_data", bus.tx_data, 8'hA0 + exp_seq[n]);
      wait_sig(1, "cont_ack", ta);
      check("cont_ack_val", bus.ack, 1 << exp_seq[n]);
      check("cont_ack_vs_start", bus.tx_start, 0);
    end
    bus.req = '0;
    tick(); tick();
    check("cont_busy_low", bus.busy, 0);
    drop_on_ack = 1;

    // Timeout then rotation to next requester, stuck one retried later
    do_reset();
    te_a = -1; te_b = -1;
    bus.req_data[0] = 8'h01;
    bus.req_data[1] = 8'h02;
    bus.req = 4'b0011;
    wait_sig(0, "to_start", ts);
    check("to_id", bus.cur_id, 0);
    wait_sig(2, "to_err", tt);
    check("to_latency", (tt - ts) / 10, 65);
    check("to_no_ack", bus.ack, 0);
    te_a = 5;
    wait_sig(0, "to_next_start", ts);
    check("to_next_id", bus.cur_id, 1);
    wait_sig(1, "to_next_ack", ta);
    wait_sig(0, "to_retry_start", ts);
    check("to_retry_id", bus.cur_id, 0);
    wait_sig(1, "to_retry_ack", ta);
    check("to_retry_ack_val", bus.ack, 4'b0001);

    // tx_end during START ignored
    te_a = 0; te_b = 5;
    bus.req_data[2] = 8'h77;
    bus.req = 4'b0100;
    wait_sig(0, "start_end_start", ts);
    wait_sig(1, "start_end_ack", ta);
    check("start_end_latency", (ta - ts) / 10, 6);
    check("start_end_id", bus.cur_id, 2);

    // tx_end on the last watchdog cycle wins; req_data change mid-frame is ignored
    te_a = 64; te_b = -1;
    bus.req_data[3] = 8'hC3;
    bus.req = 4'b1000;
    wait_sig(0, "edge_start", ts);
    repeat (10) tick();
    bus.req_data[3] = 8'h3C;
    wait_sig(1, "edge_ack", ta);
    check("edge_latency", (ta - ts) / 10, 65);
    check("edge_ack_val", bus.ack, 4'b1000);
    check("edge_no_err", bus.timeout_err, 0);
    check("edge_data_held", bus.tx_data, 8'hC3);

    // Reset mid-WAIT
    te_a = -1; te_b = -1;
    bus.req_data[2] = 8'h99;
    bus.req = 4'b0100;
    wait_sig(0, "mid_start", ts);
    repeat (5) tick();
    #2 reset = 1;
    #1;
    check("mid_busy", bus.busy, 0);
    check("mid_ack", bus.ack, 0);
    check("mid_err", bus.timeout_err, 0);
    check("mid_data", bus.tx_data, 0);
    @(negedge clk);
    bus.req_data[0] = 8'h42;
    bus.req = 4'b0001;
    te_a = 3;
    @(negedge clk);
    reset = 0;
    wait_sig(0, "post_rst_start", ts);
    check("post_rst_id", bus.cur_id, 0);
    check("post_rst_data", bus.tx_data, 8'h42);
    wait_sig(1, "post_rst_ack", ta);
    check("post_rst_ack_val", bus.ack, 4'b0001);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between N_REQ byte requesters using round-robin arbitration.
- Latches the winner's byte, pulses tx_start, waits for the transmitter's tx_end, then acks the winner.
- A watchdog aborts a frame if tx_end never arrives, so one stuck transfer cannot lock up the link.
- Sits between the on-chip byte producers and the single transmitter instance.

Parameters:
- DATA_WIDTH, 8: byte width; must match the transmitter's DATA_WIDTH.
- N_REQ, 4: number of requesters (2..8).
- ID_WIDTH, 2: width of the requester index; must be >= clog2(N_REQ).
- TIMEOUT, 64: cycles in WAIT without tx_end before abort (>= 2).
- CNT_WIDTH, 7: watchdog counter width; 2**CNT_WIDTH must be > TIMEOUT.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  bit i high = requester i has a byte pending; held until ack[i].
- req_data  in  N_REQ*DATA_WIDTH  byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  N_REQ  one-hot, 1-cycle pulse: requester i's byte fully sent.
- tx_data  out  DATA_WIDTH  to transmitter i_DATA.
- tx_start  out  1  to transmitter tx_start; 1-cycle pulse.
- tx_end  in  1  from transmitter; completion pulse.
- busy  out  1  high in every state except IDLE.
- cur_id  out  ID_WIDTH  index of the granted requester; valid while busy.
- timeout_err  out  1  1-cycle pulse when the watchdog aborts a frame.

Behaviour:
- Reset (async, immediate) clears all outputs and registers:
  - ack=0, tx_data=0, tx_start=0, busy=0, cur_id=0, timeout_err=0.
  - state=IDLE, rr_ptr=N_REQ-1 (so requester 0 has first priority), watchdog counter=0.
- FSM states: IDLE, START, WAIT, DONE, ERR. All outputs are registered or decoded from registered state; no combinational path from any input to any output.
- IDLE:
  - If req is nonzero, pick the first set bit scanning from rr_ptr+1 upward, wrapping modulo N_REQ.
  - Register cur_id and tx_data = that requester's byte, then go to START.
  - If req is zero, stay in IDLE.
- START:
  - tx_start=1 for exactly this one cycle; counter=0.
  - Always go to WAIT.
  - tx_end seen in START is ignored.
- WAIT:
  - counter increments every cycle.
  - If tx_end=1: go to DONE (tx_end takes priority over timeout in the same cycle).
  - Else if counter==TIMEOUT-1: go to ERR.
- DONE:
  - ack[cur_id]=1 for one cycle; rr_ptr=cur_id; go to IDLE.
- ERR:
  - timeout_err=1 for one cycle; no ack; rr_ptr=cur_id; go to IDLE.
  - The requester keeps req high, gets retried later, and cannot starve the others.
- tx_data and cur_id hold stable from IDLE exit until the next grant. Changes to req_data after the grant have no effect on the frame in flight.
- Requester contract: drop req (or present the next byte) on the same edge at which it samples ack high. IDLE following DONE then sees the updated req.
- Latency:
  - req sampled at edge E0 in IDLE → tx_start high during cycle E0..E1.
  - tx_end sampled at edge Ek → ack high during Ek..Ek+1.
  - Minimum gap between successive tx_start pulses: 3 cycles plus the transmitter frame time.
- tx_end arriving in IDLE, DONE or ERR is ignored.
- A req bit that falls before its grant is simply skipped; no error.
- Reset asserted mid-WAIT aborts the frame silently: no ack, no timeout_err.
- Fairness: under continuous requests from all requesters, grants rotate in strict sequence 0,1,…,N_REQ-1,0.

Test Plan:
- Single request: reset, then req=4'b0100 with byte 8'hDB → tx_data=8'hDB, cur_id=2, one tx_start pulse; tx_end 10 cycles later → ack=4'b0100 one cycle later, busy falls.
- Simultaneous requests: req=4'b1010 from reset → grant order 1 then 3; after 3, req=4'b0010 → 1 again; each byte appears on tx_data in that order.
- Continuous requests: req=4'b1111 held, tx_end model after 12 cycles → cur_id sequence 0,1,2,3,0,1; exactly one ack per frame; ack never overlaps tx_start.
- Timeout: TIMEOUT=64, tx_end held low → timeout_err pulse 65 cycles after tx_start, no ack, next grant goes to the next requester in rotation.
- Boundary: tx_end in START ignored (frame still waits in WAIT); tx_end on the same cycle counter reaches TIMEOUT-1 → ack, not timeout_err; req_data changed during WAIT → tx_data unchanged.
- Reset mid-WAIT → all outputs 0 immediately, no ack or timeout_err; after release with req=4'b0001 → grant 0.
